imem_boot_ctrl: RTL and testbench

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

---
 rtl/imem_boot_ctrl_pkg.sv | 15 +
 rtl/imem_boot_ctrl_if.sv | 24 ++
 rtl/imem_boot_ctrl_fetch_decode.sv | 16 +
 rtl/imem_boot_ctrl.sv | 102 ++++++++++
 tb/tb_imem_boot_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot controller:
// FSM state encoding and the instruction fed to the CPU while it is stalled or faulting.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } boot_state_e;

    // RISC-V "addi x0, x0, 0"
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Loader handshake plus external memory port of the boot controller.
// master: the environment (image loader and memory array); slave: the controller.
interface imem_boot_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              ld_valid;
    logic              ld_ready;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output ld_valid, ld_data, ld_last, mem_rdata,
        input  ld_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, mem_rdata,
        output ld_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_boot_ctrl_fetch_decode.sv
// Combinational fetch address decode: byte PC -> word address, plus fault detect
// for misaligned PCs and PCs beyond the memory window.
module imem_fetch_decode #(
    parameter int ADDR_W = 8
) (
    input  logic [31:0]       pc,
    output logic [ADDR_W-1:0] word_addr,
    output logic              fault
);

    assign word_addr = pc[ADDR_W+1:2];

    // Any low byte-offset bit or any bit above the window is a fault.
    assign fault = (|pc[1:0]) || (|pc[31:ADDR_W+2]);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot controller for an external instruction memory: streams a loader image into
// the memory, then hands the memory to the CPU for zero-latency fetch.
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    imem_boot_ctrl_if.slave   bus,
    input  logic [31:0]       PC_Out,
    output logic [31:0]       instruction,
    output logic              cpu_stall,
    output logic              fetch_fault,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    boot_state_e       state, state_nxt;
    logic              ld_ready_q;
    logic              stall_q;
    logic              accept;
    logic              is_run;
    logic [ADDR_W-1:0] dec_addr;
    logic              dec_fault;

    imem_fetch_decode #(.ADDR_W(ADDR_W)) u_dec (
        .pc        (PC_Out),
        .word_addr (dec_addr),
        .fault     (dec_fault)
    );

    assign accept = ld_ready_q && bus.ld_valid;
    assign is_run = (state == ST_RUN);

    // Next-state: start_load always wins and (re)enters LOAD from any state.
    always_comb begin
        state_nxt = state;
        if (start_load) begin
            state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept && bus.ld_last)
                        state_nxt = ST_RUN;
                    else if (accept && (word_count == LAST_IDX))
                        state_nxt = ST_ERR;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // State, registered handshake/stall outputs, word counter and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BOOT;
            ld_ready_q <= 1'b0;
            stall_q    <= 1'b1;
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ld_ready_q <= (state_nxt == ST_LOAD);
            stall_q    <= (state_nxt != ST_RUN);
            if (start_load) begin
                // A word accepted in this cycle is still written; only the count restarts.
                word_count <= '0;
                load_done  <= 1'b0;
                load_err   <= 1'b0;
            end else if (accept) begin
                word_count <= word_count + 1'b1;
                if (bus.ld_last)
                    load_done <= 1'b1;
                else if (word_count == LAST_IDX)
                    load_err <= 1'b1;
            end
        end
    end

    // Memory port: loader writes in LOAD, CPU fetch address in RUN.
    always_comb begin
        bus.ld_ready  = ld_ready_q;
        bus.mem_we    = accept;
        bus.mem_wdata = accept ? bus.ld_data : 32'h0;
        bus.mem_addr  = is_run ? dec_addr : word_count[ADDR_W-1:0];
    end

    // CPU side: NOP unless running with a valid fetch address.
    always_comb begin
        cpu_stall   = stall_q;
        fetch_fault = is_run && dec_fault;
        instruction = (is_run && !dec_fault) ? bus.mem_rdata : NOP_INSN;
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: directed load/fetch/overflow/reset
// scenarios followed by randomized traffic, all checked every cycle against
// a behavioural model of the controller.
module tb_imem_boot_ctrl;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int M_BOOT = 0, M_LOAD = 1, M_RUN = 2, M_ERR = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_load;
    logic [31:0]       PC_Out;
    logic [31:0]       instruction;
    logic              cpu_stall, fetch_fault, load_done, load_err;
    logic [ADDR_W:0]   word_count;

    imem_boot_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_load  (start_load),
        .bus         (bus),
        .PC_Out      (PC_Out),
        .instruction (instruction),
        .cpu_stall   (cpu_stall),
        .fetch_fault (fetch_fault),
        .load_done   (load_done),
        .load_err    (load_err),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    // External memory array (asynchronous read)
    logic [31:0] mem [DEPTH];
    int          last_wr_addr = -1;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            last_wr_addr      <= int'(bus.mem_addr);
        end
    end
    always_comb bus.mem_rdata = mem[bus.mem_addr];

    // Behavioural model
    int          m_mode;
    int          m_cnt;
    bit          m_done, m_err;
    logic [31:0] ref_mem [DEPTH];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cyc();
        bit          acc, flt;
        int          widx;
        @(negedge clk);
        acc  = (m_mode == M_LOAD) && bus.ld_valid;
        widx = int'(PC_Out / 4);
        flt  = (m_mode == M_RUN) && ((PC_Out % 4) != 0 || PC_Out >= 32'(4 * DEPTH));
        chk("ld_ready",    32'(bus.ld_ready), 32'(m_mode == M_LOAD));
        chk("cpu_stall",   32'(cpu_stall),    32'(m_mode != M_RUN));
        chk("mem_we",      32'(bus.mem_we),   32'(acc));
        chk("mem_wdata",   bus.mem_wdata,     acc ? bus.ld_data : 32'h0);
        if (acc) chk("mem_addr_wr", 32'(bus.mem_addr), 32'(m_cnt));
        chk("fetch_fault", 32'(fetch_fault),  32'(flt));
        if (m_mode == M_RUN && !flt) begin
            chk("mem_addr_rd", 32'(bus.mem_addr), 32'(widx));
            chk("instruction", instruction, ref_mem[widx]);
        end else begin
            chk("instruction", instruction, NOP);
        end
        chk("word_count", 32'(word_count), 32'(m_cnt));
        chk("load_done",  32'(load_done),  32'(m_done));
        chk("load_err",   32'(load_err),   32'(m_err));
        @(posedge clk);
        if (rst) begin
            m_mode = M_BOOT; m_cnt = 0; m_done = 0; m_err = 0;
        end else begin
            if (acc) ref_mem[m_cnt] = bus.ld_data;
            if (start_load) begin
                m_mode = M_LOAD; m_cnt = 0; m_done = 0; m_err = 0;
            end else if (acc) begin
                m_cnt++;
                if (bus.ld_last) begin
                    m_mode = M_RUN; m_done = 1;
                end else if (m_cnt == DEPTH) begin
                    m_mode = M_ERR; m_err = 1;
                end
            end
        end
        #1;
    endtask

    task automatic pulse_start();
        start_load = 1'b1; cyc(); start_load = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        bus.ld_valid = 1'b1; bus.ld_data = d; bus.ld_last = last;
        cyc();
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 32'h0; ref_mem[i] = 32'h0;
        end
        rst = 1'b1; start_load = 1'b0; PC_Out = 32'h0;
        bus.ld_valid = 1'b0; bus.ld_data = 32'h0; bus.ld_last = 1'b0;
        @(posedge clk); #1;
        m_mode = M_BOOT; m_cnt = 0; m_done = 0; m_err = 0;
        cyc();                                  // reset held: checks reset state
        rst = 1'b0;
        cyc(); cyc();                           // idle in BOOT
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_instr", instruction, NOP);

        // Three-word image
        pulse_start();
        send(32'h0050_0293, 1'b0);
        send(32'h0020_0b13, 1'b0);
        send(32'h00f4_2403, 1'b1);
        chk("load3_wc",    32'(word_count), 32'd3);
        chk("load3_done",  32'(load_done),  32'd1);
        chk("load3_stall", 32'(cpu_stall),  32'd0);
        chk("load3_lastwr", 32'(last_wr_addr), 32'd2);

        // Fetch and faults
        PC_Out = 32'd8; #1;
        chk("fetch8_addr",  32'(bus.mem_addr), 32'd2);
        chk("fetch8_instr", instruction, 32'h00f4_2403);
        chk("fetch8_fault", 32'(fetch_fault), 32'd0);
        cyc();
        PC_Out = 32'd6; #1;
        chk("pc6_fault", 32'(fetch_fault), 32'd1);
        chk("pc6_instr", instruction, NOP);
        cyc();
        PC_Out = 32'h400; #1;
        chk("pc400_fault", 32'(fetch_fault), 32'd1);
        chk("pc400_instr", instruction, NOP);
        cyc();

        // Overflow: DEPTH words, never ld_last
        PC_Out = 32'h0;
        pulse_start();
        for (int i = 0; i < DEPTH; i++) send($urandom, 1'b0);
        chk("ovf_lastwr", 32'(last_wr_addr), 32'd255);
        chk("ovf_wc",     32'(word_count), 32'd256);
        chk("ovf_err",    32'(load_err),   32'd1);
        chk("ovf_stall",  32'(cpu_stall),  32'd1);
        chk("ovf_rdy",    32'(bus.ld_ready), 32'd0);
        bus.ld_valid = 1'b1; cyc(); bus.ld_valid = 1'b0;   // ignored in ERR

        // Reload from ERR
        pulse_start();
        chk("rel_err_clr", 32'(load_err),   32'd0);
        chk("rel_wc_clr",  32'(word_count), 32'd0);
        send(32'hdead_beef, 1'b1);
        chk("rel_done", 32'(load_done),  32'd1);
        chk("rel_wc",   32'(word_count), 32'd1);

        // Mid-load reset
        pulse_start();
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b0);
        rst = 1'b1; bus.ld_valid = 1'b1; cyc(); rst = 1'b0;
        chk("mrst_rdy", 32'(bus.ld_ready), 32'd0);
        chk("mrst_wc",  32'(word_count),   32'd0);
        chk("mrst_we",  32'(bus.mem_we),   32'd0);
        cyc(); cyc();
        bus.ld_valid = 1'b0;

        // Restart inside LOAD with a coincident word
        pulse_start();
        send(32'haaaa_0000, 1'b0);
        start_load = 1'b1; bus.ld_valid = 1'b1; bus.ld_data = 32'h5555_0001; bus.ld_last = 1'b1;
        cyc();
        start_load = 1'b0; bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        chk("rst_in_load_wc", 32'(word_count), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            start_load   = ($urandom_range(0, 39) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            bus.ld_valid = $urandom_range(0, 2) != 0;
            bus.ld_data  = $urandom;
            bus.ld_last  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) < 8) PC_Out = 32'(4 * $urandom_range(0, DEPTH - 1));
            else                          PC_Out = $urandom;
            cyc();
        end
        rst = 1'b0; start_load = 1'b0; bus.ld_valid = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
